// File: rtl/spi_slave_responder.sv
// SPI target: oversamples SCLK/CS_n/MOSI in the i_Clk domain, receives bytes MSb first and
// returns bytes from a one-deep TX holding buffer on MISO. All four SPI modes via SPI_MODE.
`timescale 1ns/1ps
module spi_slave_responder #(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic CPOL = ((SPI_MODE / 2) % 2) == 1;
  localparam logic CPHA = (SPI_MODE % 2) == 1;

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sclk_prev_reg;
  logic                   cs_n_prev_reg;

  logic       sclk_s;
  logic       cs_n_s;
  logic       mosi_s;

  logic [7:0] rx_sr_reg,    rx_sr_next;
  logic [7:0] tx_sr_reg,    tx_sr_next;
  logic [2:0] bit_cnt_reg,  bit_cnt_next;
  logic [7:0] rx_byte_reg,  rx_byte_next;
  logic       rx_dv_reg,    rx_dv_next;
  logic [7:0] buf_reg,      buf_next;
  logic       buf_full_reg, buf_full_next;
  logic       underrun_reg, underrun_next;

  logic selected;
  logic leading_edge;
  logic trailing_edge;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;
  logic load_event;

  // Synchronizer chains idle at SCLK=CPOL, CS_n=1 so reset never fakes an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sclk_sync_reg <= {SYNC_STAGES{CPOL}};
      cs_sync_reg   <= {SYNC_STAGES{1'b1}};
      mosi_sync_reg <= '0;
      sclk_prev_reg <= CPOL;
      cs_n_prev_reg <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0],   i_SPI_CS_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_SPI_MOSI};
      sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
      cs_n_prev_reg <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_n_s = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  assign selected      = ~cs_n_s;
  assign leading_edge  = selected & (sclk_prev_reg == CPOL) & (sclk_s != CPOL);
  assign trailing_edge = selected & (sclk_prev_reg != CPOL) & (sclk_s == CPOL);
  assign sample_edge   = CPHA ? trailing_edge : leading_edge;
  assign shift_edge    = CPHA ? leading_edge  : trailing_edge;
  assign cs_fall       = cs_n_prev_reg & ~cs_n_s;
  assign cs_rise       = ~cs_n_prev_reg & cs_n_s;
  // A shift edge at bit 0 presents the next byte's MSb; CPHA=0 also needs it at select time.
  assign load_event    = (shift_edge & (bit_cnt_reg == 3'd0)) | (~CPHA & cs_fall);

  always_comb begin
    rx_sr_next    = rx_sr_reg;
    tx_sr_next    = tx_sr_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_byte_next  = rx_byte_reg;
    rx_dv_next    = 1'b0;
    buf_next      = buf_reg;
    buf_full_next = buf_full_reg;
    underrun_next = 1'b0;

    if (cs_rise) begin
      bit_cnt_next = 3'd0;
      rx_sr_next   = 8'h00;
      tx_sr_next   = 8'h00;
    end else begin
      if (sample_edge) begin
        rx_sr_next   = {rx_sr_reg[6:0], mosi_s};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          rx_byte_next = {rx_sr_reg[6:0], mosi_s};
          rx_dv_next   = 1'b1;
        end
      end
      if (load_event) begin
        tx_sr_next    = buf_full_reg ? buf_reg : 8'h00;
        underrun_next = ~buf_full_reg;
        buf_full_next = 1'b0;
      end else if (shift_edge) begin
        tx_sr_next = {tx_sr_reg[6:0], 1'b0};
      end
    end

    // Acceptance looks at the pre-load state, so a byte offered while full is dropped.
    if (i_TX_DV && !buf_full_reg) begin
      buf_next      = i_TX_Byte;
      buf_full_next = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_sr_reg    <= 8'h00;
      tx_sr_reg    <= 8'h00;
      bit_cnt_reg  <= 3'd0;
      rx_byte_reg  <= 8'h00;
      rx_dv_reg    <= 1'b0;
      buf_reg      <= 8'h00;
      buf_full_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      rx_sr_reg    <= rx_sr_next;
      tx_sr_reg    <= tx_sr_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_byte_reg  <= rx_byte_next;
      rx_dv_reg    <= rx_dv_next;
      buf_reg      <= buf_next;
      buf_full_reg <= buf_full_next;
      underrun_reg <= underrun_next;
    end
  end

  assign o_TX_Ready    = ~buf_full_reg;
  assign o_TX_Underrun = underrun_reg;
  assign o_RX_DV       = rx_dv_reg;
  assign o_RX_Byte     = rx_byte_reg;
  assign o_SPI_MISO    = tx_sr_reg[7] & selected;
  assign o_SPI_MISO_En = selected;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: one instance per SPI mode driven by a behavioural master;
// expected RX/MISO bytes are queued by the stimulus and checked by independent monitors.
`timescale 1ns/1ps
module tb_spi_slave_responder;

  localparam int HP = 8;

  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  logic       clk;
  logic       i_Rst;
  logic [3:0] sclk, cs_n, mosi, miso, miso_en;
  logic [3:0] tx_dv, tx_ready, underrun, rx_dv;
  logic [7:0] tx_byte [4];
  logic [7:0] rx_byte [4];

  int vectors;
  int miscompares;
  int underrun_cnt [4];

  exp_t exp_rx_q[$];
  exp_t exp_miso_q[$];

  logic       miso_done;
  int         miso_idx;
  logic [7:0] miso_byte;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave_responder #(.SPI_MODE(gi), .SYNC_STAGES(2)) u_dut (
        .i_Clk         (clk),
        .i_Rst         (i_Rst),
        .i_TX_Byte     (tx_byte[gi]),
        .i_TX_DV       (tx_dv[gi]),
        .o_TX_Ready    (tx_ready[gi]),
        .o_TX_Underrun (underrun[gi]),
        .o_RX_DV       (rx_dv[gi]),
        .o_RX_Byte     (rx_byte[gi]),
        .i_SPI_Clk     (sclk[gi]),
        .i_SPI_CS_n    (cs_n[gi]),
        .i_SPI_MOSI    (mosi[gi]),
        .o_SPI_MISO    (miso[gi]),
        .o_SPI_MISO_En (miso_en[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic f_cpol(input int m);
    return ((m / 2) % 2) == 1;
  endfunction

  function automatic logic f_cpha(input int m);
    return (m % 2) == 1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(negedge clk);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_assert(input int m);
    @(negedge clk);
    cs_n[m] = 1'b0;
    wait_cyc(HP);
  endtask

  task automatic cs_release(input int m);
    wait_cyc(HP);
    cs_n[m] = 1'b1;
    wait_cyc(2 * HP);
  endtask

  // Master side: shifts nbits of b out MSb first and captures MISO at each sample edge.
  task automatic spi_bits(input int m, input logic [7:0] b, input int nbits);
    logic [7:0] rx;
    logic       cpol;
    rx   = 8'h00;
    cpol = f_cpol(m);
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!f_cpha(m)) begin
        mosi[m] = b[i];
        wait_cyc(HP);
        rx      = {rx[6:0], miso[m]};
        sclk[m] = ~cpol;
        wait_cyc(HP);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = b[i];
        wait_cyc(HP);
        rx      = {rx[6:0], miso[m]};
        sclk[m] = cpol;
        wait_cyc(HP);
      end
    end
    if (nbits == 8) begin
      miso_idx  = m;
      miso_byte = rx;
      miso_done = 1'b1;
      @(negedge clk);
      miso_done = 1'b0;
    end
  endtask

  task automatic expect_xfer(input int m, input logic [7:0] rx_b, input logic [7:0] miso_b);
    exp_t e;
    e.idx = m;
    e.b   = rx_b;
    exp_rx_q.push_back(e);
    e.b   = miso_b;
    exp_miso_q.push_back(e);
  endtask

  task automatic wait_ready(input int m);
    int n;
    n = 0;
    while (!tx_ready[m] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[m]) begin
      vectors++;
      miscompares++;
      $display("FAIL burst_ready_timeout actual=0 required=1");
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!i_Rst && underrun[i]) underrun_cnt[i]++;
      if (rx_dv[i]) begin
        if (exp_rx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_unexpected dut=%0d actual=%0h required=none", i, rx_byte[i]);
        end else begin
          exp_t e;
          e = exp_rx_q.pop_front();
          check($sformatf("rx_dut_m%0d", e.idx), i, e.idx);
          check($sformatf("rx_byte_m%0d", e.idx), rx_byte[i], e.b);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (miso_done) begin
      if (exp_miso_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL miso_unexpected dut=%0d actual=%0h required=none", miso_idx, miso_byte);
      end else begin
        exp_t e;
        e = exp_miso_q.pop_front();
        check($sformatf("miso_dut_m%0d", e.idx), miso_idx, e.idx);
        check($sformatf("miso_byte_m%0d", e.idx), miso_byte, e.b);
      end
    end
  end

  initial begin
    int uc;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 4; i++) begin
      underrun_cnt[i] = 0;
      tx_byte[i]      = 8'h00;
    end
    sclk      = 4'b1100;
    cs_n      = 4'b1111;
    mosi      = 4'b0000;
    tx_dv     = 4'b0000;
    miso_done = 1'b0;
    miso_idx  = 0;
    miso_byte = 8'h00;
    i_Rst     = 1'b1;
    wait_cyc(4);
    check("rst_tx_ready", tx_ready, 4'hF);
    check("rst_underrun", underrun, 4'h0);
    check("rst_rx_dv", rx_dv, 4'h0);
    check("rst_rx_byte0", rx_byte[0], 8'h00);
    check("rst_miso", miso, 4'h0);
    check("rst_miso_en", miso_en, 4'h0);
    i_Rst = 1'b0;
    wait_cyc(4);

    // Mode 0 single byte with preloaded buffer.
    load_tx(0, 8'hA5);
    check("m0_ready_after_load", tx_ready[0], 1'b0);
    expect_xfer(0, 8'h3C, 8'hA5);
    cs_assert(0);
    check("m0_ready_after_cs_load", tx_ready[0], 1'b1);
    check("m0_miso_en_selected", miso_en[0], 1'b1);
    spi_bits(0, 8'h3C, 8);
    cs_release(0);
    check("m0_miso_en_released", miso_en[0], 1'b0);

    // Modes 1..3 same exchange.
    for (int m = 1; m < 4; m++) begin
      load_tx(m, 8'hC3);
      expect_xfer(m, 8'h5A, 8'hC3);
      cs_assert(m);
      spi_bits(m, 8'h5A, 8);
      cs_release(m);
    end
    check("m1_no_underrun_loaded", underrun_cnt[1], 0);

    // Mode 0 three-byte burst, buffer refilled whenever ready.
    load_tx(0, 8'h11);
    expect_xfer(0, 8'hA1, 8'h11);
    expect_xfer(0, 8'hB2, 8'h22);
    expect_xfer(0, 8'hC3, 8'h33);
    cs_assert(0);
    fork
      begin
        spi_bits(0, 8'hA1, 8);
        spi_bits(0, 8'hB2, 8);
        spi_bits(0, 8'hC3, 8);
      end
      begin
        wait_ready(0);
        load_tx(0, 8'h22);
        wait_ready(0);
        load_tx(0, 8'h33);
      end
    join
    cs_release(0);

    // Mode 1 with empty buffer: zeros on MISO, exactly one underrun.
    uc = underrun_cnt[1];
    expect_xfer(1, 8'h96, 8'h00);
    cs_assert(1);
    spi_bits(1, 8'h96, 8);
    cs_release(1);
    check("m1_underrun_pulses", underrun_cnt[1] - uc, 1);

    // Mode 0 partial byte dropped on deselect, then a full byte.
    cs_assert(0);
    spi_bits(0, 8'hF0, 4);
    cs_release(0);
    expect_xfer(0, 8'h81, 8'h00);
    cs_assert(0);
    spi_bits(0, 8'h81, 8);
    cs_release(0);

    // Mode 0 reset mid-byte with a byte sitting in the buffer.
    cs_assert(0);
    load_tx(0, 8'h5C);
    check("m0_ready_before_rst", tx_ready[0], 1'b0);
    spi_bits(0, 8'hFF, 3);
    @(negedge clk);
    i_Rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_ready", tx_ready[0], 1'b1);
    check("midrst_underrun", underrun[0], 1'b0);
    check("midrst_rx_dv", rx_dv[0], 1'b0);
    check("midrst_rx_byte", rx_byte[0], 8'h00);
    check("midrst_miso", miso[0], 1'b0);
    check("midrst_miso_en", miso_en[0], 1'b0);
    cs_n[0] = 1'b1;
    mosi[0] = 1'b0;
    wait_cyc(4);
    i_Rst = 1'b0;
    wait_cyc(4);
    expect_xfer(0, 8'hE7, 8'h00);
    cs_assert(0);
    spi_bits(0, 8'hE7, 8);
    cs_release(0);

    wait_cyc(20);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("miso_queue_drained", exp_miso_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
